apb2axi_rd_engine: RTL and testbench

AXI-domain consumer of the read-request FIFO. It pops committed read command entries, issues them on the AXI AR channel, and accepts R-channel beats. Each beat is forwarded through a registered stage into the read-response FIFO, which the gateway uses for APB read completion. Outstanding reads are bounded by a credit counter.

---
 rtl/apb2axi_pkg.sv | 39 +++
 rtl/apb2axi_rd_engine_if.sv | 51 +++++
 rtl/apb2axi_skid_reg.sv | 31 +++
 rtl/apb2axi_rd_engine.sv | 103 ++++++++++
 tb/tb_apb2axi_rd_engine.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb2axi_pkg.sv
// Shared types and widths for the APB-to-AXI read engine: command entries,
// read-response entries, AXI response codes and the AR state encoding.
package apb2axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 6;
  localparam int TAG_W      = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                  is_write;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            burst;
    logic [2:0]            size;
    logic [7:0]            len;
    logic [AXI_ADDR_W-1:0] addr;
  } directory_entry_t;

  localparam int CMD_ENTRY_W = $bits(directory_entry_t);

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } rd_rsp_entry_t;

  localparam int RD_RSP_W = $bits(rd_rsp_entry_t);

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_t;

endpackage

// File: rtl/apb2axi_rd_engine_if.sv
// Bus bundle between the read engine and its environment: command FIFO pop
// port, AXI AR and R channels, and the read-response FIFO push port.
interface apb2axi_rd_engine_if;
  import apb2axi_pkg::*;

  logic                   rd_pop_vld;
  logic [CMD_ENTRY_W-1:0] rd_pop_data;
  logic                   rd_pop_rdy;

  logic                  arvalid;
  logic                  arready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [AXI_ID_W-1:0]   arid;

  logic                  rvalid;
  logic                  rready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic [AXI_ID_W-1:0]   rid;
  logic                  rlast;

  logic                rsp_push_vld;
  logic                rsp_push_rdy;
  logic [RD_RSP_W-1:0] rsp_push_data;

  modport master (
    input  rd_pop_vld, rd_pop_data,
    output rd_pop_rdy,
    output arvalid, araddr, arlen, arsize, arburst, arid,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output rsp_push_vld, rsp_push_data,
    input  rsp_push_rdy
  );

  modport slave (
    output rd_pop_vld, rd_pop_data,
    input  rd_pop_rdy,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  rsp_push_vld, rsp_push_data,
    output rsp_push_rdy
  );

endinterface

// File: rtl/apb2axi_skid_reg.sv
// One-entry output register from the AXI R channel to the response FIFO.
// Ready is combinational so a full-rate stream passes without bubbles.
module apb2axi_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy
);

  // Held low during reset so no beat is taken before the engine is live.
  assign in_rdy = !rst && (!out_vld || out_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (out_vld && out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/apb2axi_rd_engine.sv
// AXI-side read engine: pops read commands, issues AR bursts under a credit
// limit, and forwards R beats to the response FIFO. States: AR_IDLE | AR_ISSUE.
module apb2axi_rd_engine
  import apb2axi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                 aclk,
  input logic                 areset,
  apb2axi_rd_engine_if.master bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  ar_state_t        state;
  logic [CNT_W-1:0] out_cnt;
  directory_entry_t entry;
  logic             can_pop;
  logic             pop;
  logic             r_acc;
  logic             dec;
  rd_rsp_entry_t    rsp_in;

  assign entry   = directory_entry_t'(bus.rd_pop_data);
  assign can_pop = bus.rd_pop_vld && (out_cnt < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    pop = 1'b0;
    if (!areset) begin
      case (state)
        AR_IDLE:  pop = can_pop;
        AR_ISSUE: pop = bus.arready && can_pop;
        default:  pop = 1'b0;
      endcase
    end
  end

  assign bus.rd_pop_rdy = pop;

  // A pop in AR_ISSUE only happens alongside arready, so reloading here
  // never disturbs an unaccepted request.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= AR_IDLE;
      bus.arvalid <= 1'b0;
      bus.araddr  <= '0;
      bus.arlen   <= '0;
      bus.arsize  <= '0;
      bus.arburst <= '0;
      bus.arid    <= '0;
    end else if (pop) begin
      state       <= AR_ISSUE;
      bus.arvalid <= 1'b1;
      bus.araddr  <= entry.addr;
      bus.arlen   <= entry.len;
      bus.arsize  <= entry.size;
      bus.arburst <= entry.burst;
      bus.arid    <= AXI_ID_W'(entry.tag);
    end else if (state == AR_ISSUE && bus.arready) begin
      state       <= AR_IDLE;
      bus.arvalid <= 1'b0;
    end
  end

  assign r_acc = bus.rvalid && bus.rready;
  // Stray final beats with no credit in use must not wrap the counter.
  assign dec   = r_acc && bus.rlast && (out_cnt != '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_cnt <= '0;
    end else if (pop && !dec) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end else if (dec && !pop) begin
      out_cnt <= out_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    rsp_in      = '0;
    rsp_in.tag  = bus.rid[TAG_W-1:0];
    rsp_in.data = bus.rdata;
    rsp_in.resp = bus.rresp;
    rsp_in.last = bus.rlast;
  end

  apb2axi_skid_reg #(
    .W (RD_RSP_W)
  ) u_rsp_reg (
    .clk      (aclk),
    .rst      (areset),
    .in_vld   (bus.rvalid),
    .in_rdy   (bus.rready),
    .in_data  (rsp_in),
    .out_vld  (bus.rsp_push_vld),
    .out_data (bus.rsp_push_data),
    .out_rdy  (bus.rsp_push_rdy)
  );

  logic unused_bits;
  assign unused_bits = ^{bus.rid[AXI_ID_W-1:TAG_W], entry.is_write};

endmodule

// File: tb/tb_apb2axi_rd_engine.sv
// Directed bench for apb2axi_rd_engine with command-FIFO model and AR / response
// scoreboards.
module tb_apb2axi_rd_engine;
  import apb2axi_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  apb2axi_rd_engine_if bus ();

  apb2axi_rd_engine #(
    .MAX_OUTSTANDING (4)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  directory_entry_t fifo[$];
  directory_entry_t ar_exp[$];
  rd_rsp_entry_t    rsp_exp[$];

  int n_assert = 0;
  int n_fail   = 0;
  int pops     = 0;
  int p0;

  logic s_pop, s_ar, s_racc, s_push;
  logic [50:0]         cap_ar;
  logic [RD_RSP_W-1:0] cap_rsp;
  rd_rsp_entry_t       cap_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic directory_entry_t mk(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [TAG_W-1:0] tag);
    directory_entry_t e;
    e          = '0;
    e.addr     = addr;
    e.len      = len;
    e.size     = 3'd2;
    e.burst    = 2'b01;
    e.tag      = tag;
    e.is_write = 1'b0;
    return e;
  endfunction

  task automatic drive_fifo();
    bus.rd_pop_vld  = (fifo.size() != 0);
    bus.rd_pop_data = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // One clock: sample handshakes before the edge, update models after it.
  task automatic cyc();
    directory_entry_t e;
    rd_rsp_entry_t    r;
    #1;
    s_pop   = bus.rd_pop_rdy && bus.rd_pop_vld;
    s_ar    = bus.arvalid && bus.arready;
    s_racc  = bus.rvalid && bus.rready;
    s_push  = bus.rsp_push_vld && bus.rsp_push_rdy;
    cap_ar  = {bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid};
    cap_rsp = bus.rsp_push_data;
    cap_r.tag  = bus.rid[TAG_W-1:0];
    cap_r.data = bus.rdata;
    cap_r.resp = bus.rresp;
    cap_r.last = bus.rlast;
    @(posedge aclk);
    #1;
    if (s_ar) begin
      if (ar_exp.size() == 0) chk("ar_unexpected", 64'(ar_exp.size()), 64'd1);
      else begin
        e = ar_exp.pop_front();
        chk("ar_fields", 64'(cap_ar), 64'({e.addr, e.len, e.size, e.burst, AXI_ID_W'(e.tag)}));
      end
    end
    if (s_pop) begin
      e = fifo.pop_front();
      assert (!e.is_write) else $fatal(1, "FAIL is_write: write entry offered to read engine");
      ar_exp.push_back(e);
      pops++;
    end
    if (s_push) begin
      if (rsp_exp.size() == 0) chk("rsp_unexpected", 64'(rsp_exp.size()), 64'd1);
      else begin
        r = rsp_exp.pop_front();
        chk("rsp_entry", 64'(cap_rsp), 64'(r));
      end
    end
    if (s_racc) rsp_exp.push_back(cap_r);
    drive_fifo();
  endtask

  task automatic send_beat(input logic [AXI_ID_W-1:0] id, input logic [31:0] data,
                           input logic [1:0] resp, input logic last);
    bus.rvalid = 1'b1;
    bus.rid    = id;
    bus.rdata  = data;
    bus.rresp  = resp;
    bus.rlast  = last;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (s_racc) break;
    end
    chk("r_accept", 64'(s_racc), 64'd1);
    bus.rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_rsp_entry_t b1;
    bus.rd_pop_vld   = 1'b1;
    bus.rd_pop_data  = mk(32'h9000, 8'd0, 4'd1);
    bus.arready      = 1'b0;
    bus.rvalid       = 1'b0;
    bus.rdata        = '0;
    bus.rresp        = '0;
    bus.rid          = '0;
    bus.rlast        = 1'b0;
    bus.rsp_push_rdy = 1'b1;

    // reset state
    #7;
    chk("rst_pop_rdy", 64'(bus.rd_pop_rdy), 64'd0);
    chk("rst_rready", 64'(bus.rready), 64'd0);
    chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("rst_rsp_vld", 64'(bus.rsp_push_vld), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_push_data), 64'd0);
    chk("rst_out_cnt", 64'(dut.out_cnt), 64'd0);
    drive_fifo();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    cyc();
    chk("rel_rready", 64'(bus.rready), 64'd1);

    // single read
    fifo.push_back(mk(32'h1000, 8'd3, 4'd2));
    drive_fifo();
    cyc();
    chk("t1_pop", 64'(s_pop), 64'd1);
    chk("t1_arvalid", 64'(bus.arvalid), 64'd1);
    chk("t1_araddr", 64'(bus.araddr), 64'h1000);
    chk("t1_arid", 64'(bus.arid), 64'd2);
    chk("t1_arlen", 64'(bus.arlen), 64'd3);
    chk("t1_cnt1", 64'(dut.out_cnt), 64'd1);
    bus.arready = 1'b1;
    cyc();
    chk("t1_ar_hs", 64'(s_ar), 64'd1);
    bus.arready = 1'b0;
    chk("t1_ar_drop", 64'(bus.arvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      send_beat(6'd2, 32'hA0 + 32'(i), AXI_RESP_OKAY, (i == 3));
      if (i == 0) chk("t1_rsp_lat", 64'(bus.rsp_push_vld), 64'd1);
    end
    cyc();
    cyc();
    chk("t1_cnt0", 64'(dut.out_cnt), 64'd0);
    chk("t1_sb_empty", 64'(rsp_exp.size()), 64'd0);

    // credit limit
    p0 = pops;
    bus.arready = 1'b1;
    for (int i = 0; i < 6; i++) fifo.push_back(mk(32'h2000 + 32'(i * 64), 8'd0, 4'(i)));
    drive_fifo();
    repeat (8) cyc();
    chk("t2_four_pops", 64'(pops - p0), 64'd4);
    chk("t2_cnt_full", 64'(dut.out_cnt), 64'd4);
    chk("t2_pop_rdy_low", 64'(bus.rd_pop_rdy), 64'd0);
    send_beat(6'd0, 32'hE0, AXI_RESP_OKAY, 1'b1);
    chk("t2_no_same_cycle_pop", 64'(pops - p0), 64'd4);
    cyc();
    chk("t2_fifth_pop", 64'(pops - p0), 64'd5);
    fifo.delete();
    drive_fifo();
    cyc();
    for (int i = 1; i < 5; i++) send_beat(6'(i), 32'hE0 + 32'(i), AXI_RESP_OKAY, 1'b1);
    cyc();
    cyc();
    chk("t2_cnt0", 64'(dut.out_cnt), 64'd0);
    bus.arready = 1'b0;

    // AR stall
    p0 = pops;
    fifo.push_back(mk(32'h3000, 8'd5, 4'd7));
    fifo.push_back(mk(32'h3100, 8'd1, 4'd8));
    drive_fifo();
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t3_araddr", 64'(bus.araddr), 64'h3000);
      chk("t3_arlen", 64'(bus.arlen), 64'd5);
      chk("t3_arid", 64'(bus.arid), 64'd7);
      chk("t3_no_pop", 64'(pops - p0), 64'd1);
    end
    bus.arready = 1'b1;
    cyc();
    chk("t3_b2b_pop", 64'(s_pop), 64'd1);
    chk("t3_reload", 64'(bus.araddr), 64'h3100);
    chk("t3_arvalid", 64'(bus.arvalid), 64'd1);
    cyc();
    bus.arready = 1'b0;
    chk("t3_idle", 64'(bus.arvalid), 64'd0);
    send_beat(6'd7, 32'hF0, AXI_RESP_OKAY, 1'b1);
    send_beat(6'd8, 32'hF1, AXI_RESP_OKAY, 1'b1);
    cyc();
    chk("t3_cnt0", 64'(dut.out_cnt), 64'd0);

    // response back-pressure (also stray rlast with no credit in use)
    bus.rsp_push_rdy = 1'b0;
    send_beat(6'd3, 32'hB1, AXI_RESP_OKAY, 1'b0);
    chk("t4_held_vld", 64'(bus.rsp_push_vld), 64'd1);
    b1 = '0;
    b1.tag  = 4'd3;
    b1.data = 32'hB1;
    b1.resp = AXI_RESP_OKAY;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hB2;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_beat2_not_taken", 64'(s_racc), 64'd0);
      chk("t4_rready_low", 64'(bus.rready), 64'd0);
      chk("t4_held_data", 64'(bus.rsp_push_data), 64'(b1));
    end
    bus.rsp_push_rdy = 1'b1;
    send_beat(6'd3, 32'hB2, AXI_RESP_OKAY, 1'b0);
    send_beat(6'd3, 32'hB3, AXI_RESP_OKAY, 1'b1);
    cyc();
    cyc();
    chk("t4_sb_empty", 64'(rsp_exp.size()), 64'd0);
    chk("t4_cnt_sat", 64'(dut.out_cnt), 64'd0);

    // error responses
    send_beat(6'd5, 32'hC0, AXI_RESP_SLVERR, 1'b0);
    chk("t5_slverr", 64'(bus.rsp_push_data[2:1]), 64'(AXI_RESP_SLVERR));
    send_beat(6'd5, 32'hC1, AXI_RESP_DECERR, 1'b1);
    chk("t5_decerr", 64'(bus.rsp_push_data[2:1]), 64'(AXI_RESP_DECERR));
    cyc();

    // pop and rlast in the same cycle
    bus.arready = 1'b1;
    fifo.push_back(mk(32'h4000, 8'd0, 4'd9));
    drive_fifo();
    cyc();
    cyc();
    chk("t5_cnt1", 64'(dut.out_cnt), 64'd1);
    fifo.push_back(mk(32'h4100, 8'd0, 4'd10));
    drive_fifo();
    bus.rvalid = 1'b1;
    bus.rid    = 6'd9;
    bus.rdata  = 32'hD9;
    bus.rresp  = AXI_RESP_OKAY;
    bus.rlast  = 1'b1;
    cyc();
    bus.rvalid = 1'b0;
    chk("t5_sim_pop", 64'(s_pop), 64'd1);
    chk("t5_sim_rlast", 64'(s_racc), 64'd1);
    chk("t5_cnt_same", 64'(dut.out_cnt), 64'd1);
    cyc();
    send_beat(6'd10, 32'hDA, AXI_RESP_OKAY, 1'b1);
    cyc();
    chk("t5_cnt0", 64'(dut.out_cnt), 64'd0);
    bus.arready = 1'b0;

    // reset mid-burst
    fifo.push_back(mk(32'h5000, 8'd2, 4'd4));
    drive_fifo();
    cyc();
    bus.rsp_push_rdy = 1'b0;
    send_beat(6'd4, 32'hD0, AXI_RESP_OKAY, 1'b0);
    chk("t6_pre_arvalid", 64'(bus.arvalid), 64'd1);
    chk("t6_pre_rsp_vld", 64'(bus.rsp_push_vld), 64'd1);
    #2;
    areset = 1'b1;
    #1;
    chk("t6_arvalid", 64'(bus.arvalid), 64'd0);
    chk("t6_araddr", 64'(bus.araddr), 64'd0);
    chk("t6_rsp_vld", 64'(bus.rsp_push_vld), 64'd0);
    chk("t6_rsp_data", 64'(bus.rsp_push_data), 64'd0);
    chk("t6_cnt", 64'(dut.out_cnt), 64'd0);
    chk("t6_rready", 64'(bus.rready), 64'd0);
    chk("t6_pop_rdy", 64'(bus.rd_pop_rdy), 64'd0);
    fifo.delete();
    ar_exp.delete();
    rsp_exp.delete();
    drive_fifo();
    bus.rsp_push_rdy = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    cyc();
    chk("t6_rel_rready", 64'(bus.rready), 64'd1);
    chk("t6_rel_arvalid", 64'(bus.arvalid), 64'd0);
    chk("t6_ar_sb_empty", 64'(ar_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
